// File: rtl/dshot_receiver.sv
// dshot_receiver: decodes one DShot300 line into a held 8-bit motor speed with CRC check and failsafe
module dshot_receiver #(
  parameter int BIT_THRESH = 30,
  parameter int MAX_HIGH   = 50,
  parameter int FRAME_GAP  = 80,
  parameter int TIMEOUT    = 160000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dshot_i,
  output logic [7:0] speed,
  output logic       speed_valid,
  output logic [5:0] cmd,
  output logic       cmd_valid,
  output logic       telem_req,
  output logic       crc_err,
  output logic       frame_err,
  output logic       timeout
);
  localparam logic [2:0] GAP = 3'd0, IDLE = 3'd1, HIGH = 3'd2, LOW = 3'd3, CHECK = 3'd4;
  localparam logic [7:0] BT = 8'(BIT_THRESH);
  localparam logic [7:0] MH = 8'(MAX_HIGH);
  localparam logic [7:0] FG = 8'(FRAME_GAP);
  localparam logic [17:0] TO = 18'(TIMEOUT);
  logic s1, dshot_s, d, rise, fall, crc_ok, valid;
  logic [2:0] state;
  logic [7:0] hi_cnt, lo_cnt, speed_n;
  logic [3:0] bit_cnt;
  logic [15:0] shreg;
  logic [17:0] to_cnt;
  logic [10:0] t;
  assign rise = dshot_s & ~d;
  assign fall = ~dshot_s & d;
  assign t = shreg[15:5];
  assign crc_ok = shreg[3:0] == (shreg[15:12] ^ shreg[11:8] ^ shreg[7:4]);
  assign valid = state == CHECK && crc_ok;
  assign speed_n = 8'((t - 11'd48) >> 3);
  // two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) {d, dshot_s, s1} <= 3'b000;
    else {d, dshot_s, s1} <= {dshot_s, s1, dshot_i};
  // frame framing FSM: measures high/low times and shifts bits in MSB first
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= GAP;
      hi_cnt <= '0;
      lo_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        GAP: begin
          lo_cnt <= dshot_s ? 8'd0 : lo_cnt + 8'(lo_cnt != 8'hff);
          if (lo_cnt >= FG) state <= IDLE;
        end
        IDLE: if (rise) begin
          state <= HIGH;
          hi_cnt <= 8'd1;
          bit_cnt <= 4'd0;
        end
        HIGH: if (hi_cnt >= MH) begin
          frame_err <= 1'b1;
          state <= GAP;
          lo_cnt <= 8'd0;
        end else if (fall) begin
          shreg <= {shreg[14:0], hi_cnt >= BT};
          if (bit_cnt == 4'd15) state <= CHECK;
          else begin
            bit_cnt <= bit_cnt + 4'd1;
            state <= LOW;
            lo_cnt <= 8'd0;
          end
        end else hi_cnt <= hi_cnt + 8'(hi_cnt != 8'hff);
        LOW: if (rise) begin
          state <= HIGH;
          hi_cnt <= 8'd1;
        end else if (lo_cnt >= FG) begin
          frame_err <= 1'b1;
          state <= IDLE;
        end else lo_cnt <= lo_cnt + 8'd1;
        CHECK: begin
          state <= GAP;
          lo_cnt <= 8'd0;
        end
        default: state <= GAP;
      endcase
    end
  // frame evaluation, held outputs and failsafe; a valid frame beats the timeout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      speed <= '0;
      speed_valid <= 1'b0;
      cmd <= '0;
      cmd_valid <= 1'b0;
      telem_req <= 1'b0;
      crc_err <= 1'b0;
      timeout <= 1'b1;
      to_cnt <= '0;
    end else begin
      speed_valid <= 1'b0;
      cmd_valid <= 1'b0;
      crc_err <= 1'b0;
      to_cnt <= valid ? 18'd0 : to_cnt + 18'(to_cnt != 18'h3ffff);
      if (valid) begin
        telem_req <= shreg[4];
        timeout <= 1'b0;
        if (t == 11'd0) begin
          speed <= 8'd0;
          speed_valid <= 1'b1;
        end else if (t < 11'd48) begin
          cmd <= t[5:0];
          cmd_valid <= 1'b1;
        end else begin
          speed <= speed_n;
          speed_valid <= 1'b1;
        end
      end else begin
        if (state == CHECK) crc_err <= 1'b1;
        if (to_cnt >= TO) begin
          timeout <= 1'b1;
          speed <= 8'd0;
        end
      end
    end
endmodule

// File: tb/tb_dshot_receiver.sv
// tb_dshot_receiver: randomized frame stimulus checked against a behavioural DShot decode model
module tb_dshot_receiver;
  localparam int TO_T = 20000;
  logic clk, rst, dshot_i;
  logic [7:0] speed;
  logic [5:0] cmd;
  logic speed_valid, cmd_valid, telem_req, crc_err, frame_err, timeout;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_sv = 0, n_cv = 0, n_ce = 0, n_fe = 0, sv_cyc = 0, k_last = 0;
  int m_speed, m_cmd, m_telem, m_to;
  dshot_receiver #(.TIMEOUT(TO_T)) dut (
    .clk(clk), .rst(rst), .dshot_i(dshot_i), .speed(speed), .speed_valid(speed_valid),
    .cmd(cmd), .cmd_valid(cmd_valid), .telem_req(telem_req), .crc_err(crc_err),
    .frame_err(frame_err), .timeout(timeout)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst) begin
    if (speed_valid) begin n_sv++; sv_cyc = cyc; end
    if (cmd_valid) n_cv++;
    if (crc_err) n_ce++;
    if (frame_err) n_fe++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] crc4(input logic [11:0] v);
    return v[11:8] ^ v[7:4] ^ v[3:0];
  endfunction
  function automatic logic [15:0] mk(input int tv, input logic tl);
    logic [11:0] v;
    v = {11'(tv), tl};
    return {v, crc4(v)};
  endfunction
  task automatic idle(input int n);
    dshot_i = 0;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bits(input logic [15:0] w, input int n, input int h0, input int h1);
    for (int i = 15; i > 15 - n; i--) begin
      int h;
      h = w[i] ? h1 : h0;
      dshot_i = 1;
      repeat (h) @(negedge clk);
      dshot_i = 0;
      k_last = cyc + 1;
      repeat (53 - h) @(negedge clk);
    end
  endtask
  task automatic reset_model();
    m_speed = 0; m_cmd = 0; m_telem = 0; m_to = 1;
  endtask
  task automatic check_outs(input string tag);
    chk({tag, ".speed"}, speed, m_speed);
    chk({tag, ".cmd"}, cmd, m_cmd);
    chk({tag, ".telem"}, telem_req, m_telem);
    chk({tag, ".timeout"}, timeout, m_to);
  endtask
  task automatic do_frame(input string tag, input logic [15:0] w, input int h0, input int h1);
    int b_sv, b_cv, b_ce, b_fe, e_sv, e_cv, e_ce, tv;
    b_sv = n_sv; b_cv = n_cv; b_ce = n_ce; b_fe = n_fe;
    send_bits(w, 16, h0, h1);
    idle(100);
    tv = int'(w[15:5]);
    e_sv = 0; e_cv = 0; e_ce = 0;
    if (w[3:0] != crc4(w[15:4])) e_ce = 1;
    else begin
      m_telem = int'(w[4]);
      m_to = 0;
      if (tv == 0) begin m_speed = 0; e_sv = 1; end
      else if (tv < 48) begin m_cmd = tv; e_cv = 1; end
      else begin m_speed = (tv - 48) / 8; e_sv = 1; end
    end
    check_outs(tag);
    chk({tag, ".n_speed_valid"}, n_sv - b_sv, e_sv);
    chk({tag, ".n_cmd_valid"}, n_cv - b_cv, e_cv);
    chk({tag, ".n_crc_err"}, n_ce - b_ce, e_ce);
    chk({tag, ".n_frame_err"}, n_fe - b_fe, 0);
    if (e_sv == 1) chk({tag, ".latency"}, sv_cyc - k_last, 3);
  endtask
  initial begin
    int b_sv, b_fe, r, tv, h0, h1;
    logic [15:0] w;
    rst = 1; dshot_i = 0;
    reset_model();
    repeat (3) @(negedge clk);
    check_outs("reset");
    chk("reset.strobes", {speed_valid, cmd_valid, crc_err, frame_err}, 0);
    rst = 0;
    idle(100);
    do_frame("f830b", 16'h830B, 20, 40);
    do_frame("f0606", 16'h0606, 20, 40);
    do_frame("fffee", 16'hFFEE, 20, 40);
    do_frame("f830b_b", 16'h830B, 20, 40);
    do_frame("f00bb", 16'h00BB, 20, 40);
    do_frame("f830a", 16'h830A, 20, 40);
    do_frame("t47", mk(47, 0), 20, 40);
    do_frame("t48", mk(48, 1), 20, 40);
    do_frame("t49", mk(49, 0), 20, 40);
    b_fe = n_fe; b_sv = n_sv;
    send_bits(16'h830B, 9, 20, 40);
    idle(200);
    chk("trunc.n_frame_err", n_fe - b_fe, 1);
    chk("trunc.n_speed_valid", n_sv - b_sv, 0);
    check_outs("trunc");
    do_frame("after_trunc", 16'h830B, 20, 40);
    b_fe = n_fe;
    dshot_i = 1;
    repeat (50) @(negedge clk);
    idle(200);
    chk("stuck.n_frame_err", n_fe - b_fe, 1);
    check_outs("stuck");
    do_frame("after_stuck", mk(900, 0), 20, 40);
    for (int i = 0; i < 20; i++) begin
      r = int'($urandom_range(0, 9));
      tv = r == 0 ? 0 : r < 3 ? int'($urandom_range(1, 47)) : int'($urandom_range(48, 2047));
      w = mk(tv, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) w = w ^ 16'(1 << $urandom_range(0, 3));
      h0 = (i % 4 == 0) ? 29 : 20;
      h1 = (i % 4 == 0) ? 30 : 40;
      do_frame("rand", w, h0, h1);
    end
    do_frame("pre_to", mk(1048, 0), 20, 40);
    b_sv = n_sv;
    idle(TO_T - 200);
    chk("to_early.timeout", timeout, 0);
    idle(400);
    m_speed = 0; m_to = 1;
    check_outs("to");
    chk("to.n_speed_valid", n_sv - b_sv, 0);
    do_frame("to_clear", mk(1048, 1), 20, 40);
    dshot_i = 1;
    repeat (10) @(negedge clk);
    rst = 1;
    #1;
    reset_model();
    check_outs("rst_mid");
    chk("rst_mid.strobes", {speed_valid, cmd_valid, crc_err, frame_err}, 0);
    @(negedge clk);
    dshot_i = 0;
    rst = 0;
    idle(100);
    do_frame("after_rst", mk(700, 0), 20, 40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
